// File: rtl/dmem_if.sv
// dmem_if: request/response handshake between the MEM stage and the data-memory responder
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_f3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    modport master (
        output req_valid, req_we, req_f3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_f3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data memory with fixed latency, lane select and range/alignment checks
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input logic   clk,
    input logic   rst,
    dmem_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic        cap_we;
    logic [2:0]  cap_f3;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
    logic [31:0] mem [DEPTH_WORDS];
    logic        accept;
    logic        enter_resp;
    logic        cur_we;
    logic [2:0]  cur_f3;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        legal_f3;
    logic        misaligned;
    logic        out_of_range;
    logic        err;
    logic [AW-1:0] idx;
    logic [31:0] word;
    logic [31:0] rsh;
    logic [31:0] ld_data;
    logic [31:0] st_data;
    logic [3:0]  be;
    assign bus.req_ready  = (state == IDLE) && !rst;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign accept = bus.req_valid && bus.req_ready;
    assign enter_resp = !rst && ((accept && LATENCY == 1) || (state == WAIT && cnt == 4'd0));
    // With LATENCY=1 the access happens on the accept edge, so use the live request
    assign cur_we    = (state == IDLE) ? bus.req_we    : cap_we;
    assign cur_f3    = (state == IDLE) ? bus.req_f3    : cap_f3;
    assign cur_addr  = (state == IDLE) ? bus.req_addr  : cap_addr;
    assign cur_wdata = (state == IDLE) ? bus.req_wdata : cap_wdata;
    always_comb begin
        legal_f3 = cur_we ? (cur_f3 == 3'b000 || cur_f3 == 3'b001 || cur_f3 == 3'b010)
                          : (cur_f3 == 3'b000 || cur_f3 == 3'b001 || cur_f3 == 3'b010 ||
                             cur_f3 == 3'b100 || cur_f3 == 3'b101);
        misaligned = (cur_f3[1:0] == 2'b01 && cur_addr[0]) ||
                     (cur_f3[1:0] == 2'b10 && cur_addr[1:0] != 2'b00);
        out_of_range = cur_addr[31:2] >= 30'(DEPTH_WORDS);
        err = !legal_f3 || misaligned || out_of_range;
        idx  = cur_addr[AW+1:2];
        word = mem[idx];
        rsh  = word >> {cur_addr[1:0], 3'b000};
        ld_data = cur_f3 == 3'b000 ? {{24{rsh[7]}}, rsh[7:0]} :
                  cur_f3 == 3'b001 ? {{16{rsh[15]}}, rsh[15:0]} :
                  cur_f3 == 3'b010 ? word :
                  cur_f3 == 3'b100 ? {24'd0, rsh[7:0]} :
                  cur_f3 == 3'b101 ? {16'd0, rsh[15:0]} : 32'd0;
        st_data = cur_f3 == 3'b000 ? {4{cur_wdata[7:0]}} :
                  cur_f3 == 3'b001 ? {2{cur_wdata[15:0]}} : cur_wdata;
        be = cur_f3 == 3'b000 ? 4'b0001 << cur_addr[1:0] :
             cur_f3 == 3'b001 ? 4'b0011 << cur_addr[1:0] : 4'b1111;
    end
    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !err)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            if (enter_resp) begin
                state        <= RESP;
                resp_valid_q <= 1'b1;
                resp_rdata_q <= (err || cur_we) ? 32'd0 : ld_data;
                resp_err_q   <= err;
            end
            case (state)
                IDLE: if (accept) begin
                    cap_we    <= bus.req_we;
                    cap_f3    <= bus.req_f3;
                    cap_addr  <= bus.req_addr;
                    cap_wdata <= bus.req_wdata;
                    if (LATENCY != 1) begin
                        state <= WAIT;
                        cnt   <= 4'(LATENCY - 2);
                    end
                end
                WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                RESP: if (bus.resp_ready) begin
                    state        <= IDLE;
                    resp_valid_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed load/store sequence with hand-computed expectations
module tb_dmem_responder;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    dmem_if bus ();
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    // Accept, WAIT, RESP with immediate consume; checks exact latency and return to IDLE
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input string tag);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_f3    = f3;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        chk({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk({tag, " early_valid"}, 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        chk({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
        chk({tag, " rdata"}, bus.resp_rdata, exp_rdata);
        chk({tag, " err"}, 32'(bus.resp_err), 32'(exp_err));
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk({tag, " done_valid"}, 32'(bus.resp_valid), 32'd0);
    endtask
    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_f3     = 3'b000;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst req_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst req_ready", 32'(bus.req_ready), 32'd1);
        xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, "sw10");
        xact(1'b0, 3'b010, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, "lw10");
        xact(1'b1, 3'b000, 32'h13, 32'h00000080, 32'd0, 1'b0, "sb13");
        xact(1'b0, 3'b000, 32'h13, 32'd0, 32'hFFFFFF80, 1'b0, "lb13");
        xact(1'b0, 3'b100, 32'h13, 32'd0, 32'h00000080, 1'b0, "lbu13");
        xact(1'b0, 3'b010, 32'h10, 32'd0, 32'h80ADBEEF, 1'b0, "lw10b");
        xact(1'b0, 3'b101, 32'h12, 32'd0, 32'h000080AD, 1'b0, "lhu12");
        xact(1'b0, 3'b001, 32'h12, 32'd0, 32'hFFFF80AD, 1'b0, "lh12");
        xact(1'b0, 3'b000, 32'h10, 32'd0, 32'hFFFFFFEF, 1'b0, "lb10");
        xact(1'b0, 3'b001, 32'h11, 32'd0, 32'd0, 1'b1, "lh11_mis");
        xact(1'b1, 3'b010, 32'h12, 32'h11112222, 32'd0, 1'b1, "sw12_mis");
        xact(1'b1, 3'b001, 32'h10, 32'hAAAA5555, 32'd0, 1'b0, "sh10");
        xact(1'b0, 3'b010, 32'h10, 32'd0, 32'h80AD5555, 1'b0, "lw10c");
        // Backpressure: response held while requester keeps asking
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_f3    = 3'b010;
        bus.req_addr  = 32'h10;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("hold valid", 32'(bus.resp_valid), 32'd1);
            chk("hold rdata", bus.resp_rdata, 32'h80AD5555);
            chk("hold req_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("release valid", 32'(bus.resp_valid), 32'd0);
        chk("release req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        chk("no second resp", 32'(bus.resp_valid), 32'd0);
        // Reset during WAIT drops the store
        xact(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'd0, 1'b0, "sw20");
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_f3    = 3'b010;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'h12345678;
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid valid", 32'(bus.resp_valid), 32'd0);
        chk("rstmid req_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rstmid ready_after", 32'(bus.req_ready), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("rstmid no_resp", 32'(bus.resp_valid), 32'd0);
        end
        xact(1'b0, 3'b010, 32'h20, 32'd0, 32'hCAFEF00D, 1'b0, "lw20");
        xact(1'b0, 3'b010, 32'd4096, 32'd0, 32'd0, 1'b1, "lw_oor");
        xact(1'b1, 3'b010, 32'd4096, 32'h55555555, 32'd0, 1'b1, "sw_oor");
        xact(1'b0, 3'b011, 32'h10, 32'd0, 32'd0, 1'b1, "f3_011");
        xact(1'b1, 3'b100, 32'h20, 32'hFFFFFFFF, 32'd0, 1'b1, "st_f3_100");
        xact(1'b1, 3'b010, 32'hFFC, 32'h0BADF00D, 32'd0, 1'b0, "sw_last");
        xact(1'b0, 3'b010, 32'hFFC, 32'd0, 32'h0BADF00D, 1'b0, "lw_last");
        xact(1'b0, 3'b010, 32'h10, 32'd0, 32'h80AD5555, 1'b0, "lw10_final");
        xact(1'b0, 3'b010, 32'h20, 32'd0, 32'hCAFEF00D, 1'b0, "lw20_final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
